// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the axi_rw_burst master.
// Holds the AXI burst, prot, cache and size encodings used on the bus,
// the OKAY response code, and the read / write FSM state enums.
package axi_pkg;

  // Burst type: every transfer is issued as INCR (single beats use len 0)
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Unprivileged, secure, data access
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // Normal non-cacheable, modifiable
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0010;

  // Transfer size encodings (log2 of bytes per beat) for the supported buses
  localparam logic [2:0] AXI_SIZE_32 = 3'd2;
  localparam logic [2:0] AXI_SIZE_64 = 3'd3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_AR,
    RD_R,
    RD_RESP
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_AW_W,
    WR_B,
    WR_RESP
  } wr_state_e;

  // Full-bus beat size for a given data width (32 or 64 bits)
  function automatic logic [2:0] axi_bus_size(input int data_width);
    return (data_width == 64) ? AXI_SIZE_64 : AXI_SIZE_32;
  endfunction

endpackage

// File: rtl/axi_align.sv
// Byte-lane alignment for single-beat AXI transfers.
// Ports:
//   offset   - low address bits selecting the first byte lane
//   size     - log2 of the transfer size in bytes
//   data_in  - right-aligned data (write) or raw bus data (read)
//   strb     - byte-lane strobes covering the transfer
//   data_out - write: data moved up to its lanes; read: data moved down to
//              bit 0 and masked to the transfer size
module axi_align #(
  parameter int DATA_WIDTH = 64,
  parameter bit READ       = 1'b0
) (
  input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
  input  logic [2:0]                      size,
  input  logic [DATA_WIDTH-1:0]           data_in,
  output logic [DATA_WIDTH/8-1:0]         strb,
  output logic [DATA_WIDTH-1:0]           data_out
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  logic [STRB_W-1:0]     byte_en;
  logic [DATA_WIDTH-1:0] byte_mask;
  logic [OFF_W+2:0]      bit_shift;

  // Bytes covered by the transfer, counted from lane 0
  always_comb begin
    for (int b = 0; b < STRB_W; b++) begin
      byte_en[b] = (b < (32'(1) << size));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_mask
      assign byte_mask[gi*8 +: 8] = {8{byte_en[gi]}};
    end
  endgenerate

  assign bit_shift = {offset, 3'b000};
  assign strb      = byte_en << offset;

  always_comb begin
    if (READ) begin
      data_out = (data_in >> bit_shift) & byte_mask;
    end else begin
      data_out = (data_in << bit_shift) & (byte_mask << bit_shift);
    end
  end

endmodule

// File: rtl/axi_rw_burst.sv
// AXI4 master issuing one read or write at a time, either a single beat of
// 1..DATA_WIDTH/8 bytes or a full line burst of BURST_LEN beats.
// Ports:
//   clock, reset           - clock and synchronous active-high reset
//   req_*                  - request handshake, direction, type, address,
//                            single-beat size and write data
//   resp_valid/rdata/err   - one-cycle completion pulse with read data and
//                            sticky error flag
//   aw_*, w_*, b_*, ar_*, r_* - AXI4 master interface
module axi_rw_burst
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic                            req_burst,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [2:0]                      req_size,
  input  logic [DATA_WIDTH*BURST_LEN-1:0] req_wdata,
  output logic                            resp_valid,
  output logic [DATA_WIDTH*BURST_LEN-1:0] resp_rdata,
  output logic                            resp_err,
  output logic [ID_WIDTH-1:0]             aw_id,
  output logic [ADDR_WIDTH-1:0]           aw_addr,
  output logic [7:0]                      aw_len,
  output logic [2:0]                      aw_size,
  output logic [1:0]                      aw_burst,
  output logic                            aw_lock,
  output logic [3:0]                      aw_cache,
  output logic [2:0]                      aw_prot,
  output logic [3:0]                      aw_qos,
  output logic [3:0]                      aw_region,
  output logic [0:0]                      aw_user,
  output logic                            aw_valid,
  input  logic                            aw_ready,
  output logic [DATA_WIDTH-1:0]           w_data,
  output logic [DATA_WIDTH/8-1:0]         w_strb,
  output logic                            w_last,
  output logic [0:0]                      w_user,
  output logic                            w_valid,
  input  logic                            w_ready,
  input  logic [ID_WIDTH-1:0]             b_id,
  input  logic [1:0]                      b_resp,
  input  logic                            b_valid,
  output logic                            b_ready,
  output logic [ID_WIDTH-1:0]             ar_id,
  output logic [ADDR_WIDTH-1:0]           ar_addr,
  output logic [7:0]                      ar_len,
  output logic [2:0]                      ar_size,
  output logic [1:0]                      ar_burst,
  output logic                            ar_lock,
  output logic [3:0]                      ar_cache,
  output logic [2:0]                      ar_prot,
  output logic [3:0]                      ar_qos,
  output logic [3:0]                      ar_region,
  output logic [0:0]                      ar_user,
  output logic                            ar_valid,
  input  logic                            ar_ready,
  input  logic [ID_WIDTH-1:0]             r_id,
  input  logic [DATA_WIDTH-1:0]           r_data,
  input  logic [1:0]                      r_resp,
  input  logic                            r_last,
  input  logic                            r_valid,
  output logic                            r_ready
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int OFF_W   = $clog2(STRB_W);
  localparam int LINE_W  = $clog2(BURST_LEN * STRB_W);
  localparam int CNT_W   = $clog2(BURST_LEN);
  localparam int LINE_DW = DATA_WIDTH * BURST_LEN;
  localparam logic [2:0]       BUS_SIZE  = axi_bus_size(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic                  burst_q, burst_d;
  logic                  write_q, write_d;
  logic [LINE_DW-1:0]    wdata_q, wdata_d;
  logic [LINE_DW-1:0]    rdata_q, rdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  err_q, err_d;

  logic req_hs, aw_hs, w_hs, b_hs, r_hs;
  logic final_beat;
  logic [ADDR_WIDTH-1:0] xfer_addr;
  logic [STRB_W-1:0]     wr_strb;
  logic [DATA_WIDTH-1:0] wr_aligned;
  logic [DATA_WIDTH-1:0] rd_aligned;
  logic [STRB_W-1:0]     unused_rd_strb;

  assign req_ready = (rd_state_q == RD_IDLE) && (wr_state_q == WR_IDLE) && !reset;
  assign req_hs    = req_valid && req_ready;
  assign aw_hs     = aw_valid && aw_ready;
  assign w_hs      = w_valid && w_ready;
  assign b_hs      = b_valid && b_ready;
  assign r_hs      = r_valid && r_ready;

  // The same beat position ends both a burst read and a burst write
  assign final_beat = !burst_q || (cnt_q == LAST_BEAT);

  // Bursts start on a line boundary; singles use the exact byte address
  assign xfer_addr = burst_q ? {addr_q[ADDR_WIDTH-1:LINE_W], {LINE_W{1'b0}}} : addr_q;

  axi_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .READ       (1'b0)
  ) u_wr_align (
    .offset   (addr_q[OFF_W-1:0]),
    .size     (size_q),
    .data_in  (wdata_q[DATA_WIDTH-1:0]),
    .strb     (wr_strb),
    .data_out (wr_aligned)
  );

  axi_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .READ       (1'b1)
  ) u_rd_align (
    .offset   (addr_q[OFF_W-1:0]),
    .size     (size_q),
    .data_in  (r_data),
    .strb     (unused_rd_strb),
    .data_out (rd_aligned)
  );

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
    end
  end

  // Next-state logic; req_ready guarantees only one FSM leaves IDLE
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE: if (req_hs && !req_write) rd_state_d = RD_AR;
      RD_AR:   if (ar_ready) rd_state_d = RD_R;
      RD_R:    if (r_hs && final_beat) rd_state_d = RD_RESP;
      RD_RESP: rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase

    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE: if (req_hs && req_write) wr_state_d = WR_AW_W;
      WR_AW_W: if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && w_last)))
                 wr_state_d = WR_B;
      WR_B:    if (b_hs) wr_state_d = WR_RESP;
      WR_RESP: wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // State-decoded outputs; AW and W run independently inside AW_W
  always_comb begin
    ar_valid   = (rd_state_q == RD_AR);
    r_ready    = (rd_state_q == RD_R);
    aw_valid   = (wr_state_q == WR_AW_W) && !aw_done_q;
    w_valid    = (wr_state_q == WR_AW_W) && !w_done_q;
    b_ready    = (wr_state_q == WR_B);
    resp_valid = (rd_state_q == RD_RESP) || (wr_state_q == WR_RESP);
  end

  // Datapath
  always_comb begin
    addr_d    = addr_q;
    size_d    = size_q;
    burst_d   = burst_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;

    if (req_hs) begin
      addr_d    = req_addr;
      size_d    = req_size;
      burst_d   = req_burst;
      write_d   = req_write;
      wdata_d   = req_wdata;
      cnt_d     = '0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      err_d     = 1'b0;
    end

    if (aw_hs) aw_done_d = 1'b1;
    if (w_hs && w_last) w_done_d = 1'b1;

    if (write_q ? w_hs : r_hs) cnt_d = cnt_q + 1'b1;

    if (r_hs) begin
      if (burst_q) begin
        rdata_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = r_data;
      end else begin
        rdata_d = LINE_DW'(rd_aligned);
      end
      // r_last must appear exactly on the beat we expect to be final
      if ((r_resp != AXI_RESP_OKAY) || (r_id != '0) || (r_last != final_beat)) begin
        err_d = 1'b1;
      end
    end

    if (b_hs && ((b_resp != AXI_RESP_OKAY) || (b_id != '0))) err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q    <= '0;
      size_q    <= '0;
      burst_q   <= 1'b0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign aw_id     = '0;
  assign aw_addr   = xfer_addr;
  assign aw_len    = burst_q ? 8'(BURST_LEN - 1) : 8'd0;
  assign aw_size   = burst_q ? BUS_SIZE : size_q;
  assign aw_burst  = AXI_BURST_INCR;
  assign aw_lock   = 1'b0;
  assign aw_cache  = AXI_CACHE_DEFAULT;
  assign aw_prot   = AXI_PROT_DEFAULT;
  assign aw_qos    = '0;
  assign aw_region = '0;
  assign aw_user   = '0;

  assign w_data = burst_q ? wdata_q[cnt_q*DATA_WIDTH +: DATA_WIDTH] : wr_aligned;
  assign w_strb = burst_q ? {STRB_W{1'b1}} : wr_strb;
  assign w_last = final_beat;
  assign w_user = '0;

  assign ar_id     = '0;
  assign ar_addr   = xfer_addr;
  assign ar_len    = burst_q ? 8'(BURST_LEN - 1) : 8'd0;
  assign ar_size   = burst_q ? BUS_SIZE : size_q;
  assign ar_burst  = AXI_BURST_INCR;
  assign ar_lock   = 1'b0;
  assign ar_cache  = AXI_CACHE_DEFAULT;
  assign ar_prot   = AXI_PROT_DEFAULT;
  assign ar_qos    = '0;
  assign ar_region = '0;
  assign ar_user   = '0;

endmodule

// File: tb/tb_axi_rw_burst.sv
module tb_axi_rw_burst;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_write, req_burst;
  logic [31:0]  req_addr;
  logic [2:0]   req_size;
  logic [255:0] req_wdata;
  logic         resp_valid, resp_err;
  logic [255:0] resp_rdata;
  logic [3:0]   aw_id, aw_cache, aw_qos, aw_region;
  logic [31:0]  aw_addr;
  logic [7:0]   aw_len;
  logic [2:0]   aw_size, aw_prot;
  logic [1:0]   aw_burst;
  logic         aw_lock, aw_valid, aw_ready;
  logic [0:0]   aw_user, w_user, ar_user;
  logic [63:0]  w_data;
  logic [7:0]   w_strb;
  logic         w_last, w_valid, w_ready;
  logic [3:0]   b_id;
  logic [1:0]   b_resp;
  logic         b_valid, b_ready;
  logic [3:0]   ar_id, ar_cache, ar_qos, ar_region;
  logic [31:0]  ar_addr;
  logic [7:0]   ar_len;
  logic [2:0]   ar_size, ar_prot;
  logic [1:0]   ar_burst;
  logic         ar_lock, ar_valid, ar_ready;
  logic [3:0]   r_id;
  logic [63:0]  r_data;
  logic [1:0]   r_resp;
  logic         r_last, r_valid, r_ready;

  int checks = 0;
  int errors = 0;

  axi_rw_burst #(
    .DATA_WIDTH (64),
    .ADDR_WIDTH (32),
    .ID_WIDTH   (4),
    .BURST_LEN  (4)
  ) dut (
    .clock (clock), .reset (reset),
    .req_valid (req_valid), .req_ready (req_ready), .req_write (req_write),
    .req_burst (req_burst), .req_addr (req_addr), .req_size (req_size),
    .req_wdata (req_wdata), .resp_valid (resp_valid), .resp_rdata (resp_rdata),
    .resp_err (resp_err),
    .aw_id (aw_id), .aw_addr (aw_addr), .aw_len (aw_len), .aw_size (aw_size),
    .aw_burst (aw_burst), .aw_lock (aw_lock), .aw_cache (aw_cache), .aw_prot (aw_prot),
    .aw_qos (aw_qos), .aw_region (aw_region), .aw_user (aw_user),
    .aw_valid (aw_valid), .aw_ready (aw_ready),
    .w_data (w_data), .w_strb (w_strb), .w_last (w_last), .w_user (w_user),
    .w_valid (w_valid), .w_ready (w_ready),
    .b_id (b_id), .b_resp (b_resp), .b_valid (b_valid), .b_ready (b_ready),
    .ar_id (ar_id), .ar_addr (ar_addr), .ar_len (ar_len), .ar_size (ar_size),
    .ar_burst (ar_burst), .ar_lock (ar_lock), .ar_cache (ar_cache), .ar_prot (ar_prot),
    .ar_qos (ar_qos), .ar_region (ar_region), .ar_user (ar_user),
    .ar_valid (ar_valid), .ar_ready (ar_ready),
    .r_id (r_id), .r_data (r_data), .r_resp (r_resp), .r_last (r_last),
    .r_valid (r_valid), .r_ready (r_ready)
  );

  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one request for a single cycle
  task automatic issue(input logic wr, input logic bu, input logic [31:0] addr,
                       input logic [2:0] size, input logic [255:0] wdata);
    req_write = wr; req_burst = bu; req_addr = addr; req_size = size; req_wdata = wdata;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
    checks++; if ({ar_valid, aw_valid, w_valid, r_ready, b_ready, resp_valid, resp_err} !== 7'b0) begin
      errors++; $display("FAIL rst_handshakes got %b exp 0000000", {ar_valid, aw_valid, w_valid, r_ready, b_ready, resp_valid, resp_err}); end
    checks++; if (resp_rdata !== 256'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
    $display("reset: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_single_read();
    ar_ready = 1'b1;
    issue(1'b0, 1'b0, 32'h8000_0004, 3'd2, 256'h0);
    checks++; if (ar_valid !== 1'b1) begin errors++; $display("FAIL sr_ar_valid got %b exp 1", ar_valid); end
    checks++; if (ar_addr !== 32'h8000_0004) begin errors++; $display("FAIL sr_ar_addr got %h exp 80000004", ar_addr); end
    checks++; if ({ar_len, ar_size, ar_id} !== {8'd0, 3'd2, 4'd0}) begin
      errors++; $display("FAIL sr_ar_fields got len %0d size %0d id %0d exp 0 2 0", ar_len, ar_size, ar_id); end
    checks++; if ({ar_cache, ar_prot, ar_lock, ar_qos} !== {4'b0010, 3'b000, 1'b0, 4'd0}) begin
      errors++; $display("FAIL sr_ar_const got cache %b prot %b exp 0010 000", ar_cache, ar_prot); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sr_resp_t1 got %b exp 0", resp_valid); end
    step();
    checks++; if ({ar_valid, r_ready, resp_valid} !== 3'b010) begin
      errors++; $display("FAIL sr_t2 got ar_valid/r_ready/resp_valid %b exp 010", {ar_valid, r_ready, resp_valid}); end
    r_valid = 1'b1; r_data = 64'h1122_3344_5566_7788; r_last = 1'b1; r_resp = 2'b00; r_id = 4'd0;
    step();
    r_valid = 1'b0; r_last = 1'b0;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL sr_resp_t3 got %b exp 1", resp_valid); end
    checks++; if (resp_rdata !== 256'h1122_3344) begin errors++; $display("FAIL sr_rdata got %h exp 11223344", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL sr_err got %b exp 0", resp_err); end
    step();
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL sr_after got resp_valid/req_ready %b exp 01", {resp_valid, req_ready}); end
    checks++; if (resp_rdata !== 256'h1122_3344) begin errors++; $display("FAIL sr_hold got %h exp 11223344", resp_rdata); end
    $display("single_read: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_single_write();
    aw_ready = 1'b1; w_ready = 1'b1;
    issue(1'b1, 1'b0, 32'h8000_0003, 3'd0, 256'hAB);
    checks++; if ({aw_valid, w_valid} !== 2'b11) begin errors++; $display("FAIL sw_valids got %b exp 11", {aw_valid, w_valid}); end
    checks++; if ({aw_addr, aw_len, aw_size} !== {32'h8000_0003, 8'd0, 3'd0}) begin
      errors++; $display("FAIL sw_aw got addr %h len %0d size %0d exp 80000003 0 0", aw_addr, aw_len, aw_size); end
    checks++; if (w_strb !== 8'h08) begin errors++; $display("FAIL sw_strb got %h exp 08", w_strb); end
    checks++; if (w_data[31:24] !== 8'hAB) begin errors++; $display("FAIL sw_data got %h exp ab in [31:24]", w_data); end
    checks++; if (w_last !== 1'b1) begin errors++; $display("FAIL sw_last got %b exp 1", w_last); end
    step();
    checks++; if ({aw_valid, w_valid, b_ready} !== 3'b001) begin
      errors++; $display("FAIL sw_b got aw/w/b_ready %b exp 001", {aw_valid, w_valid, b_ready}); end
    b_valid = 1'b1; b_resp = 2'b00; b_id = 4'd0;
    step();
    b_valid = 1'b0;
    checks++; if ({resp_valid, resp_err} !== 2'b10) begin
      errors++; $display("FAIL sw_resp got valid/err %b exp 10", {resp_valid, resp_err}); end
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sw_one_pulse got %b exp 0", resp_valid); end
    $display("single_write: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_burst_read();
    logic [255:0] exp_line;
    logic [63:0]  beat;
    ar_ready = 1'b1;
    issue(1'b0, 1'b1, 32'h8000_0018, 3'd0, 256'h0);
    checks++; if (ar_addr !== 32'h8000_0000) begin errors++; $display("FAIL br_ar_addr got %h exp 80000000", ar_addr); end
    checks++; if ({ar_len, ar_size, ar_burst} !== {8'd3, 3'd3, 2'b01}) begin
      errors++; $display("FAIL br_ar_fields got len %0d size %0d burst %b exp 3 3 01", ar_len, ar_size, ar_burst); end
    step();
    for (int i = 0; i < 4; i++) begin
      beat = {32'hD0D0_0000 + 32'(i), 32'h1111_0000 + 32'(i)};
      exp_line[i*64 +: 64] = beat;
      checks++; if ({r_ready, resp_valid} !== 2'b10) begin
        errors++; $display("FAIL br_beat%0d got r_ready/resp_valid %b exp 10", i, {r_ready, resp_valid}); end
      r_valid = 1'b1; r_data = beat; r_last = (i == 3); r_resp = 2'b00; r_id = 4'd0;
      step();
    end
    r_valid = 1'b0; r_last = 1'b0;
    checks++; if ({resp_valid, resp_err} !== 2'b10) begin
      errors++; $display("FAIL br_resp got valid/err %b exp 10", {resp_valid, resp_err}); end
    checks++; if (resp_rdata !== exp_line) begin errors++; $display("FAIL br_rdata got %h exp %h", resp_rdata, exp_line); end
    step();
    $display("burst_read: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_burst_write();
    logic [255:0] line;
    int           last_count;
    for (int i = 0; i < 4; i++) line[i*64 +: 64] = {32'hCAFE_0000 + 32'(i), 32'h5555_0000 + 32'(i)};
    last_count = 0;
    aw_ready = 1'b0; w_ready = 1'b1;
    issue(1'b1, 1'b1, 32'h8000_0040, 3'd0, line);
    checks++; if ({aw_addr, aw_len, aw_size} !== {32'h8000_0040, 8'd3, 3'd3}) begin
      errors++; $display("FAIL bw_aw got addr %h len %0d size %0d exp 80000040 3 3", aw_addr, aw_len, aw_size); end
    for (int s = 0; s < 4; s++) begin
      checks++; if ({aw_valid, w_valid} !== 2'b11) begin
        errors++; $display("FAIL bw_valid%0d got %b exp 11", s, {aw_valid, w_valid}); end
      checks++; if ({w_data, w_strb} !== {line[s*64 +: 64], 8'hFF}) begin
        errors++; $display("FAIL bw_data%0d got %h/%h exp %h/ff", s, w_data, w_strb, line[s*64 +: 64]); end
      checks++; if (w_last !== (s == 3)) begin errors++; $display("FAIL bw_last%0d got %b exp %b", s, w_last, (s == 3)); end
      if (w_last === 1'b1) last_count++;
      step();
    end
    checks++; if ({aw_valid, w_valid, b_ready} !== 3'b100) begin
      errors++; $display("FAIL bw_w_done got aw/w/b_ready %b exp 100", {aw_valid, w_valid, b_ready}); end
    checks++; if (last_count !== 1) begin errors++; $display("FAIL bw_last_count got %0d exp 1", last_count); end
    aw_ready = 1'b1;
    step();
    aw_ready = 1'b0;
    checks++; if ({aw_valid, b_ready, resp_valid} !== 3'b010) begin
      errors++; $display("FAIL bw_b got aw_valid/b_ready/resp %b exp 010", {aw_valid, b_ready, resp_valid}); end
    b_valid = 1'b1; b_resp = 2'b00; b_id = 4'd0;
    step();
    b_valid = 1'b0;
    checks++; if ({resp_valid, resp_err} !== 2'b10) begin
      errors++; $display("FAIL bw_resp got valid/err %b exp 10", {resp_valid, resp_err}); end
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bw_one_pulse got %b exp 0", resp_valid); end
    aw_ready = 1'b1;
    $display("burst_write: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_read_slverr();
    ar_ready = 1'b1;
    issue(1'b0, 1'b1, 32'h8000_0100, 3'd0, 256'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      r_valid = 1'b1; r_data = 64'(i); r_last = (i == 3); r_id = 4'd0;
      r_resp = (i == 2) ? 2'b10 : 2'b00;
      step();
    end
    r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00;
    checks++; if ({resp_valid, resp_err} !== 2'b11) begin
      errors++; $display("FAIL slverr got valid/err %b exp 11", {resp_valid, resp_err}); end
    step();
    $display("read_slverr: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_read_early_last();
    ar_ready = 1'b1;
    issue(1'b0, 1'b1, 32'h8000_0120, 3'd0, 256'h0);
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL early_err_cleared got %b exp 0", resp_err); end
    step();
    for (int i = 0; i < 4; i++) begin
      r_valid = 1'b1; r_data = 64'(i); r_resp = 2'b00; r_id = 4'd0;
      r_last = (i == 1) || (i == 3);
      step();
    end
    r_valid = 1'b0; r_last = 1'b0;
    checks++; if ({resp_valid, resp_err} !== 2'b11) begin
      errors++; $display("FAIL early_last got valid/err %b exp 11", {resp_valid, resp_err}); end
    step();
    $display("read_early_last: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_write_bid_error();
    aw_ready = 1'b1; w_ready = 1'b1;
    issue(1'b1, 1'b0, 32'h8000_0200, 3'd3, 256'h0123_4567_89AB_CDEF);
    checks++; if ({w_strb, w_data, resp_err} !== {8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0}) begin
      errors++; $display("FAIL bid_w got strb %h data %h err %b exp ff 0123456789abcdef 0", w_strb, w_data, resp_err); end
    step();
    b_valid = 1'b1; b_resp = 2'b00; b_id = 4'd1;
    step();
    b_valid = 1'b0; b_id = 4'd0;
    checks++; if ({resp_valid, resp_err} !== 2'b11) begin
      errors++; $display("FAIL bid_err got valid/err %b exp 11", {resp_valid, resp_err}); end
    step();
    $display("write_bid_error: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid();
    ar_ready = 1'b1;
    issue(1'b0, 1'b1, 32'h8000_0300, 3'd0, 256'h0);
    step();
    r_valid = 1'b1; r_data = 64'hAAAA; r_last = 1'b0; r_resp = 2'b00; r_id = 4'd0;
    step();
    r_data = 64'hBBBB;
    reset = 1'b1;
    step();
    reset = 1'b0; r_valid = 1'b0;
    #1;
    checks++; if ({r_ready, req_ready} !== 2'b01) begin
      errors++; $display("FAIL midrst got r_ready/req_ready %b exp 01", {r_ready, req_ready}); end
    checks++; if (resp_rdata !== 256'h0) begin errors++; $display("FAIL midrst_rdata got %h exp 0", resp_rdata); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_resp%0d got %b exp 0", i, resp_valid); end
      step();
    end
    $display("reset_mid: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_back_to_back();
    ar_ready = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", req_ready); end
    issue(1'b0, 1'b0, 32'h8000_0006, 3'd1, 256'h0);
    step();
    r_valid = 1'b1; r_data = 64'h1122_3344_5566_7788; r_last = 1'b1; r_resp = 2'b00; r_id = 4'd0;
    step();
    r_valid = 1'b0; r_last = 1'b0;
    checks++; if ({resp_valid, resp_rdata} !== {1'b1, 256'h1122}) begin
      errors++; $display("FAIL b2b_rd got valid %b rdata %h exp 1 1122", resp_valid, resp_rdata); end
    step();
    aw_ready = 1'b1; w_ready = 1'b1;
    issue(1'b1, 1'b0, 32'h8000_0002, 3'd1, 256'hBEEF);
    checks++; if ({w_strb, w_data} !== {8'h0C, 64'h0000_0000_BEEF_0000}) begin
      errors++; $display("FAIL b2b_wr got strb %h data %h exp 0c 00000000beef0000", w_strb, w_data); end
    step();
    b_valid = 1'b1; b_resp = 2'b00; b_id = 4'd0;
    step();
    b_valid = 1'b0;
    checks++; if ({resp_valid, resp_err} !== 2'b10) begin
      errors++; $display("FAIL b2b_wr_resp got valid/err %b exp 10", {resp_valid, resp_err}); end
    step();
    $display("back_to_back: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_burst = 1'b0;
    req_addr = '0; req_size = '0; req_wdata = '0;
    aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
    b_valid = 1'b0; b_resp = '0; b_id = '0;
    r_valid = 1'b0; r_data = '0; r_resp = '0; r_last = 1'b0; r_id = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_burst_read();
    test_burst_write();
    test_read_slverr();
    test_read_early_last();
    test_write_bid_error();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rw_burst.md
AXI_RW_BURST -- requirements
Module: axi_rw_burst

Interface
REQ-001 Parameter: DATA_WIDTH, 64, AXI data width in bits; SHALL be 32 or 64.
REQ-002 Parameter: ADDR_WIDTH, 32, AXI and request address width.
REQ-003 Parameter: ID_WIDTH, 4, AXI ID width; all issued IDs SHALL be 0.
REQ-004 Parameter: BURST_LEN, 4, beats per line burst; SHALL be a power of 2 in the range 2..16.
REQ-005 clock  input  1  clock.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 req_valid / req_ready  input / output  1 / 1  request handshake.
REQ-008 req_write  input  1  request direction: 1 = write, 0 = read.
REQ-009 req_burst  input  1  request type: 1 = line burst of BURST_LEN beats, 0 = single beat.
REQ-010 req_addr  input  ADDR_WIDTH  byte address.
REQ-011 req_size  input  3  single-beat size, log2 of bytes; ignored for bursts.
REQ-012 req_wdata  input  DATA_WIDTH*BURST_LEN  write data; beat 0 in the LSBs; singles use beat 0 only.
REQ-013 resp_valid  output  1  one-cycle completion pulse.
REQ-014 resp_rdata  output  DATA_WIDTH*BURST_LEN  read data, beat 0 in the LSBs; singles are right-aligned and zero-extended.
REQ-015 resp_err  output  1  error flag, valid with resp_valid.
REQ-016 AXI4 master ports aw_*, w_*, b_*, ar_*, r_*: full AXI4 set, directions per the AXI4 master role, widths from the parameters.

Function
REQ-017 Read FSM SHALL use states IDLE, AR, R, RESP. Write FSM SHALL use states IDLE, AW_W, B, RESP. Only one of the two FSMs SHALL be non-IDLE at a time.
REQ-018 req_ready SHALL equal (both FSMs IDLE) and not reset.
REQ-019 On req_valid & req_ready, the block SHALL register addr, size, burst, write and wdata, then enter AR or AW_W.
REQ-020 AR state: ar_valid=1 until ar handshake, then enter R. AW and W SHALL be issued concurrently. Each channel SHALL drop its valid after its own handshake. AW_W SHALL exit to B once both channels are complete.
REQ-021 Burst requests: len = BURST_LEN-1; size = log2(DATA_WIDTH/8); burst = INCR; address = req_addr with the low log2(BURST_LEN*DATA_WIDTH/8) bits cleared; wstrb = all ones.
REQ-022 Single requests: len = 0; size = req_size; address = req_addr; wstrb = ((1<<(1<<size))-1) << addr[log2(DATA_WIDTH/8)-1:0]; wdata shifted left by offset*8; rdata shifted right by offset*8 and masked to the size.
REQ-023 A beat counter SHALL index data beats. Each r handshake SHALL store beat[cnt]. w_last SHALL be 1 exactly on beat BURST_LEN-1, or on beat 0 for singles.
REQ-024 r_ready SHALL be 1 in R. b_ready SHALL be 1 in B. Neither SHALL be 1 elsewhere.
REQ-025 Leaving R SHALL occur on the handshake of the expected final beat, enter RESP. A b handshake SHALL enter RESP. RESP SHALL assert resp_valid for one cycle, then return to IDLE.
REQ-026 resp_err SHALL be set on any of the following, and SHALL be cleared on the next request acceptance:
- any r_resp or b_resp != OKAY;
- r_last not matching the final-beat position;
- r_id or b_id != 0.
REQ-027 Latency with an always-ready slave and r_valid one cycle after AR: req handshake at T, ar handshake at T+1, single r beat at T+2, resp_valid at T+3.
REQ-028 Constant AXI fields:
- prot = 000;
- lock = 0;
- qos = 0; region = 0; user = 0;
- arcache = 0010; awcache = 0010.
REQ-029 While no request is outstanding, resp_rdata SHALL hold its last value.

Reset
REQ-030 While reset is high, the following SHALL be 0 the following cycle: both FSMs = IDLE; the beat counter; all valids and readies; resp_valid; resp_err; resp_rdata.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction without waiting for outstanding beats. No resp_valid SHALL be produced for the abandoned transaction.

Structure
REQ-032 Package axi_pkg SHALL hold the following; the block SHALL import it:
- burst, prot, cache and size constants;
- the read and write state enums;
- the OKAY response code.
REQ-033 Strobe generation and data alignment SHALL be a combinational sub-module axi_align (inputs addr offset, size, data; outputs strb and shifted data), instantiated for write and read.

Verification
REQ-034 Single read, addr 0x80000004, size 2, slave returns 0x1122334455667788 -> resp_rdata 0x11223344, resp_err 0, resp_valid at T+3.
REQ-035 Single write, addr 0x80000003, size 0, data 0xAB -> w_strb 0x08, w_data[31:24]=0xAB, w_last 1, one resp_valid.
REQ-036 Burst read, addr 0x80000018, BURST_LEN 4 -> ar_addr 0x80000000, ar_len 3; beats 0..3 placed in order; resp_valid after the 4th beat.
REQ-037 Burst write with slave aw_ready delayed 3 cycles, w_ready always 1 -> all 4 W beats complete before the AW handshake, w_last only on beat 3, single b, resp_valid.
REQ-038 Read with r_resp=SLVERR on beat 2, plus a second run with r_last early on beat 1 -> resp_err 1 in both cases.
REQ-039 Reset pulse during R beat 1 -> the cycle after reset, r_ready=0, req_ready=1, and no resp_valid is produced.
